drop_controller: RTL and testbench

- Upstream stage of the connect-four win checker: owns the board register file and the current-move state.
- Accepts column moves over a valid/ready handshake and scans the chosen column bottom-up, one row per cycle, for the landing row.
- Writes the piece, then drives current_row/current_col/current_player/board_vec into the direction checker. It samples the checker's OR-reduced win flag one cycle later and decides win, draw or next turn.

---
 rtl/drop_controller.sv | 172 +++++++++++++++++
 tb/tb_drop_controller.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/drop_controller.sv
// rtl/drop_controller.sv - connect-four drop stage: board storage, column scan, move placement and result decision
module drop_controller #(
  parameter int ROWS     = 8,
  parameter int COLS     = 8,
  parameter int ROW_BITS = 3,
  parameter int COL_BITS = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   new_game,
  input  logic                   move_valid,
  input  logic [COL_BITS-1:0]    move_col,
  output logic                   move_ready,
  input  logic                   win_detect,
  output logic [ROW_BITS-1:0]    current_row,
  output logic [COL_BITS-1:0]    current_col,
  output logic [1:0]             current_player,
  output logic [ROWS*COLS*2-1:0] board_vec,
  output logic                   move_done,
  output logic                   move_rejected,
  output logic                   game_over,
  output logic [1:0]             winner
);

  localparam int CELLS    = ROWS * COLS;
  localparam int CNT_BITS = $clog2(CELLS + 1);
  localparam logic [CNT_BITS-1:0] LAST_MOVE = CNT_BITS'(CELLS - 1);
  localparam logic [ROW_BITS-1:0] TOP_ROW   = ROW_BITS'(ROWS - 1);
  localparam logic [COL_BITS:0]   COL_LIMIT = (COL_BITS + 1)'(COLS);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SCAN  = 3'd1,
    PLACE = 3'd2,
    CHECK = 3'd3,
    OVER  = 3'd4
  } state_t;

  state_t state;
  state_t state_next;

  logic [1:0]          cells [ROWS][COLS];
  logic [ROW_BITS-1:0] row_ptr;
  logic [CNT_BITS-1:0] move_count;

  logic clear;
  logic accept;
  logic col_bad;
  logic scan_empty;
  logic scan_top;
  logic board_full;

  assign clear      = rst | new_game;
  assign accept     = move_valid & move_ready;
  assign col_bad    = {1'b0, move_col} >= COL_LIMIT;
  assign scan_empty = cells[row_ptr][current_col] == 2'b00;
  assign scan_top   = row_ptr == TOP_ROW;
  assign board_full = move_count == LAST_MOVE;

  // Flatten the cell array so the direction checker sees every cell combinationally.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      assign board_vec[((r * COLS + c) * 2) +: 2] = cells[r][c];
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept && !col_bad) begin
          state_next = SCAN;
        end
      end
      SCAN: begin
        if (scan_empty) begin
          state_next = PLACE;
        end else if (scan_top) begin
          state_next = IDLE;
        end
      end
      PLACE: state_next = CHECK;
      CHECK: begin
        if (win_detect || board_full) begin
          state_next = OVER;
        end else begin
          state_next = IDLE;
        end
      end
      OVER:    state_next = OVER;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    move_ready = 1'b0;
    if (state == IDLE) begin
      move_ready = 1'b1;
    end
  end

  // Board, move registers and one-cycle result pulses.
  always_ff @(posedge clk) begin
    if (clear) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          cells[r][c] <= 2'b00;
        end
      end
      row_ptr        <= '0;
      move_count     <= '0;
      current_row    <= '0;
      current_col    <= '0;
      current_player <= 2'b01;
      move_done      <= 1'b0;
      move_rejected  <= 1'b0;
      game_over      <= 1'b0;
      winner         <= 2'b00;
    end else begin
      move_done     <= 1'b0;
      move_rejected <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (col_bad) begin
              move_rejected <= 1'b1;
            end else begin
              current_col <= move_col;
              row_ptr     <= '0;
            end
          end
        end
        SCAN: begin
          if (scan_empty) begin
            current_row <= row_ptr;
          end else if (scan_top) begin
            move_rejected <= 1'b1;
          end else begin
            row_ptr <= row_ptr + 1'b1;
          end
        end
        PLACE: begin
          cells[current_row][current_col] <= current_player;
        end
        CHECK: begin
          move_done <= 1'b1;
          if (win_detect) begin
            winner    <= current_player;
            game_over <= 1'b1;
          end else if (board_full) begin
            winner    <= 2'b00;
            game_over <= 1'b1;
          end else begin
            move_count     <= move_count + 1'b1;
            current_player <= {current_player[0], current_player[1]};
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_drop_controller.sv
// tb/tb_drop_controller.sv - directed self-checking bench for drop_controller (8x8, 8x7 and 2x2 boards)
module tb_drop_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // 8x8 instance
  logic         a_ng = 0, a_valid = 0, a_win = 0;
  logic [2:0]   a_col = 0;
  logic         a_ready, a_done, a_rej, a_over;
  logic [2:0]   a_row, a_ccol;
  logic [1:0]   a_player, a_winner;
  logic [127:0] a_board;

  drop_controller u_dut (
    .clk(clk), .rst(rst), .new_game(a_ng), .move_valid(a_valid), .move_col(a_col),
    .move_ready(a_ready), .win_detect(a_win), .current_row(a_row), .current_col(a_ccol),
    .current_player(a_player), .board_vec(a_board), .move_done(a_done),
    .move_rejected(a_rej), .game_over(a_over), .winner(a_winner)
  );

  // 8 rows x 7 columns instance
  logic         c_valid = 0;
  logic [2:0]   c_col = 0;
  logic         c_ready, c_done, c_rej, c_over;
  logic [2:0]   c_row, c_ccol;
  logic [1:0]   c_player, c_winner;
  logic [111:0] c_board;

  drop_controller #(.ROWS(8), .COLS(7), .ROW_BITS(3), .COL_BITS(3)) u_c7 (
    .clk(clk), .rst(rst), .new_game(1'b0), .move_valid(c_valid), .move_col(c_col),
    .move_ready(c_ready), .win_detect(1'b0), .current_row(c_row), .current_col(c_ccol),
    .current_player(c_player), .board_vec(c_board), .move_done(c_done),
    .move_rejected(c_rej), .game_over(c_over), .winner(c_winner)
  );

  // 2x2 instance
  logic       s_valid = 0;
  logic [0:0] s_col = 0;
  logic       s_ready, s_done, s_rej, s_over;
  logic [0:0] s_row, s_ccol;
  logic [1:0] s_player, s_winner;
  logic [7:0] s_board;

  drop_controller #(.ROWS(2), .COLS(2), .ROW_BITS(1), .COL_BITS(1)) u_s (
    .clk(clk), .rst(rst), .new_game(1'b0), .move_valid(s_valid), .move_col(s_col),
    .move_ready(s_ready), .win_detect(1'b0), .current_row(s_row), .current_col(s_ccol),
    .current_player(s_player), .board_vec(s_board), .move_done(s_done),
    .move_rejected(s_rej), .game_over(s_over), .winner(s_winner)
  );

  logic [127:0] exp_board;
  logic [1:0]   exp_player;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] put(input logic [127:0] b, input int r, input int c, input logic [1:0] p);
    logic [127:0] nb;
    nb = b;
    nb[((r * 8 + c) * 2) +: 2] = p;
    return nb;
  endfunction

  function automatic logic [1:0] other(input logic [1:0] p);
    return (p == 2'b01) ? 2'b10 : 2'b01;
  endfunction

  // Handshake in the current cycle T, return cycles until done/rejected (bounded).
  task automatic move_a(input logic [2:0] col, input logic win, output int lat,
                        output logic got_done, output logic got_rej);
    a_win = win; a_col = col; a_valid = 1'b1;
    tick();
    a_valid = 1'b0; lat = 1;
    while (!a_done && !a_rej && lat < 30) begin
      tick();
      lat++;
    end
    got_done = a_done; got_rej = a_rej;
    a_win = 1'b0;
  endtask

  task automatic move_s(input logic [0:0] col, output int lat, output logic got_done);
    s_col = col; s_valid = 1'b1;
    tick();
    s_valid = 1'b0; lat = 1;
    while (!s_done && !s_rej && lat < 30) begin
      tick();
      lat++;
    end
    got_done = s_done;
  endtask

  task automatic restart_a();
    a_ng = 1'b1;
    tick();
    a_ng = 1'b0;
    exp_board = '0;
    exp_player = 2'b01;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic d, j, any_pulse;
    int cols_p1 [4];
    cols_p1[0] = 0; cols_p1[1] = 1; cols_p1[2] = 2; cols_p1[3] = 3;

    repeat (2) tick();
    rst = 1'b0;
    tick();
    exp_board = '0;
    exp_player = 2'b01;

    chk("reset_board", a_board, 128'h0);
    chk("reset_player", a_player, 2'b01);
    chk("reset_ready", a_ready, 1'b1);
    chk("reset_over", a_over, 1'b0);
    chk("reset_winner", a_winner, 2'b00);
    chk("reset_pulses", {a_done, a_rej}, 2'b00);
    chk("reset_rowcol", {a_row, a_ccol}, 6'd0);

    // first move into empty column 3
    move_a(3'd3, 1'b0, lat, d, j);
    chk("m1_latency", lat, 4);
    chk("m1_done", {d, j}, 2'b10);
    chk("m1_board", a_board, 128'h40);
    chk("m1_row", a_row, 3'd0);
    chk("m1_col", a_ccol, 3'd3);
    chk("m1_player", a_player, 2'b10);
    chk("m1_ready", a_ready, 1'b1);
    exp_board = put(exp_board, 0, 3, 2'b01);
    exp_player = 2'b10;
    tick();
    chk("m1_pulse_width", a_done, 1'b0);

    // fill column 5 bottom-up; latency grows by one per stacked piece
    for (int k = 0; k < 8; k++) begin
      move_a(3'd5, 1'b0, lat, d, j);
      exp_board = put(exp_board, k, 5, exp_player);
      exp_player = other(exp_player);
      chk($sformatf("fill5_lat_k%0d", k), lat, 4 + k);
      chk($sformatf("fill5_board_k%0d", k), a_board, exp_board);
    end
    chk("fill5_top_row", a_row, 3'd7);
    chk("fill5_player", a_player, exp_player);

    move_a(3'd5, 1'b0, lat, d, j);
    chk("full_latency", lat, 9);
    chk("full_rejected", {d, j}, 2'b01);
    chk("full_board", a_board, exp_board);
    chk("full_player", a_player, exp_player);
    chk("full_ready", a_ready, 1'b1);

    // win: P1 on cols 0..3, P2 stacking col 6, win flagged on the 7th move
    restart_a();
    chk("ng_board", a_board, 128'h0);
    for (int i = 0; i < 7; i++) begin
      if (i % 2 == 0) begin
        move_a(3'(cols_p1[i / 2]), (i == 6), lat, d, j);
        exp_board = put(exp_board, 0, cols_p1[i / 2], 2'b01);
        chk($sformatf("win_p1_lat_%0d", i), lat, 4);
      end else begin
        move_a(3'd6, 1'b0, lat, d, j);
        exp_board = put(exp_board, i / 2, 6, 2'b10);
        chk($sformatf("win_p2_lat_%0d", i), lat, 4 + i / 2);
      end
      chk($sformatf("win_done_%0d", i), {d, j}, 2'b10);
    end
    chk("win_board", a_board, exp_board);
    chk("win_winner", a_winner, 2'b01);
    chk("win_over", a_over, 1'b1);
    chk("win_ready", a_ready, 1'b0);

    a_col = 3'd4; a_valid = 1'b1; any_pulse = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      any_pulse = any_pulse | a_done | a_rej;
    end
    a_valid = 1'b0;
    chk("over_ignored_pulse", any_pulse, 1'b0);
    chk("over_ignored_board", a_board, exp_board);
    chk("over_sticky", {a_over, a_winner, a_ready}, 4'b1010);

    // new_game while scanning a column holding 3 pieces
    restart_a();
    for (int i = 0; i < 3; i++) begin
      move_a(3'd2, 1'b0, lat, d, j);
      chk($sformatf("stack2_lat_%0d", i), lat, 4 + i);
    end
    chk("stack2_player", a_player, 2'b10);
    a_col = 3'd2; a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    tick();
    chk("midscan_busy", a_ready, 1'b0);
    a_ng = 1'b1;
    tick();
    a_ng = 1'b0;
    chk("midscan_board", a_board, 128'h0);
    chk("midscan_ready", a_ready, 1'b1);
    chk("midscan_player", a_player, 2'b01);
    any_pulse = a_done | a_rej;
    for (int i = 0; i < 6; i++) begin
      tick();
      any_pulse = any_pulse | a_done | a_rej;
    end
    chk("midscan_no_pulse", any_pulse, 1'b0);
    move_a(3'd0, 1'b0, lat, d, j);
    chk("after_ng_lat", lat, 4);
    chk("after_ng_board", a_board, 128'h1);

    // out-of-range column on a 7-column board
    c_col = 3'd7; c_valid = 1'b1;
    tick();
    c_valid = 1'b0;
    chk("oor_rejected", {c_done, c_rej}, 2'b01);
    chk("oor_board", c_board, 112'h0);
    chk("oor_ready", c_ready, 1'b1);
    chk("oor_player", c_player, 2'b01);
    tick();
    chk("oor_pulse_width", c_rej, 1'b0);

    // 2x2 board filled without a win ends in a draw
    for (int i = 0; i < 4; i++) begin
      move_s(1'(i % 2), lat, d);
      chk($sformatf("draw_lat_%0d", i), lat, 4 + i / 2);
      chk($sformatf("draw_done_%0d", i), d, 1'b1);
      if (i == 2) chk("draw_not_yet", s_over, 1'b0);
    end
    chk("draw_over", s_over, 1'b1);
    chk("draw_winner", s_winner, 2'b00);
    chk("draw_ready", s_ready, 1'b0);
    chk("draw_board", s_board, 8'h99);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
